// File: rtl/chan_mux_pkg.sv
// Shared constants for the channel multiplexer: mode encoding, default sizes
// and the select-width helper.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  localparam int N_CH_DEF = 8;
  localparam int W_DEF    = 8;

  // Channel-index width; never narrower than one bit.
  function automatic int selw_f(input int n);
    int c;
    c = $clog2(n);
    if (c < 1) begin
      return 1;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/chan_mux_seq_rr_pick.sv
// Round-robin picker: first requesting channel at or above ptr, wrapping
// from N_CH-1 back to 0. Purely combinational.
module rr_pick
  import chan_mux_pkg::*;
#(
  parameter int  N_CH = N_CH_DEF,
  localparam int SELW = selw_f(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic found_s;
  int   k_s;

  // Walk channels in priority order starting at ptr and grant the first hit
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    k_s     = 0;
    for (int j = 0; j < N_CH; j++) begin
      k_s = (int'(ptr) + j) % N_CH;
      if (!found_s && req[k_s]) begin
        found_s    = 1'b1;
        gnt[k_s]   = 1'b1;
        gnt_idx    = SELW'(k_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/chan_mux_seq.sv
// N-channel to one registered multiplexer with fixed-select and round-robin
// scan modes. Optional macro CHAN_MUX_CHMASK_EN adds a per-channel enable mask.
module chan_mux_seq
  import chan_mux_pkg::*;
#(
  parameter int  N_CH = N_CH_DEF,
  parameter int  W    = W_DEF,
  localparam int SELW = selw_f(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CHAN_MUX_CHMASK_EN
  input  logic [N_CH-1:0] ch_en,
`endif
  input  logic [N_CH*W-1:0] i,
  input  logic [N_CH-1:0] i_vld,
  output logic [N_CH-1:0] i_rdy,
  input  logic [SELW-1:0] s,
  input  logic            mode,
  output logic [W-1:0]    o,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [SELW-1:0] o_ch
);

  logic [N_CH-1:0] vld_eff_s;
  logic [N_CH-1:0] fixed_gnt_s;
  logic [N_CH-1:0] scan_gnt_s;
  logic [N_CH-1:0] cap_gnt_s;
  logic [SELW-1:0] scan_idx_s;
  logic [SELW-1:0] cap_idx_s;
  logic [SELW-1:0] ptr_nxt_s;
  logic [W-1:0]    cap_data_s;
  logic            free_s;
  logic            capture_s;

  logic [W-1:0]    o_r;
  logic            o_vld_r;
  logic [SELW-1:0] o_ch_r;
  logic [SELW-1:0] ptr_r;

`ifdef CHAN_MUX_CHMASK_EN
  assign vld_eff_s = i_vld & ch_en;
`else
  assign vld_eff_s = i_vld;
`endif

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (vld_eff_s),
    .ptr     (ptr_r),
    .gnt     (scan_gnt_s),
    .gnt_idx (scan_idx_s)
  );

  // Choose the candidate for this cycle and decide whether it is accepted
  always_comb begin
    fixed_gnt_s = '0;
    cap_data_s  = '0;
    // An out-of-range select matches no channel, so it can never capture
    for (int k = 0; k < N_CH; k++) begin
      fixed_gnt_s[k] = vld_eff_s[k] && (s == SELW'(k));
    end
    if (mode == MODE_SCAN) begin
      cap_gnt_s = scan_gnt_s;
      cap_idx_s = scan_idx_s;
    end else begin
      cap_gnt_s = fixed_gnt_s;
      cap_idx_s = s;
    end
    free_s    = ~o_vld_r | o_rdy;
    capture_s = free_s & (|cap_gnt_s) & ~rst;
    for (int k = 0; k < N_CH; k++) begin
      cap_data_s = cap_data_s | ({W{cap_gnt_s[k]}} & i[k*W +: W]);
    end
    if (capture_s) begin
      i_rdy = cap_gnt_s;
    end else begin
      i_rdy = '0;
    end
    if (cap_idx_s == SELW'(N_CH - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = cap_idx_s + SELW'(1);
    end
  end

  // Output register and scan pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r     <= '0;
      o_vld_r <= 1'b0;
      o_ch_r  <= '0;
      ptr_r   <= '0;
    end else if (capture_s) begin
      o_r     <= cap_data_s;
      o_vld_r <= 1'b1;
      o_ch_r  <= cap_idx_s;
      if (mode == MODE_SCAN) begin
        ptr_r <= ptr_nxt_s;
      end
    end else if (o_rdy) begin
      o_vld_r <= 1'b0;
    end
  end

  assign o     = o_r;
  assign o_vld = o_vld_r;
  assign o_ch  = o_ch_r;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Self-checking bench for chan_mux_seq: directed vector table, reset and
// backpressure sequences, and randomized traffic against a reference model.
module tb_chan_mux_seq;

  logic        clk;
  logic        rst;
  logic [63:0] i;
  logic [7:0]  i_vld;
  logic [7:0]  i_rdy;
  logic [2:0]  s;
  logic        mode;
  logic [7:0]  o;
  logic        o_vld;
  logic        o_rdy;
  logic [2:0]  o_ch;
  logic [7:0]  ch_en_v;

  logic [47:0] i6;
  logic [5:0]  i_vld6;
  logic [5:0]  i_rdy6;
  logic [2:0]  s6;
  logic        mode6;
  logic [7:0]  o6;
  logic        o_vld6;
  logic        o_rdy6;
  logic [2:0]  o_ch6;
  logic [5:0]  ch_en6;

  logic [7:0]  dat [8];

  int checks;
  int errors;

  // reference model state
  logic        m_vld;
  logic [7:0]  m_o;
  int          m_ch;
  int          m_ptr;

  typedef struct {
    logic       md;
    logic [2:0] sel;
    logic [7:0] vld;
    logic       rdy;
    logic [7:0] e_rdy;
    logic       e_vld;
    logic [2:0] e_ch;
    logic [7:0] e_o;
  } vec_t;

  vec_t tbl[$];

  chan_mux_seq dut (
    .clk   (clk),
    .rst   (rst),
`ifdef CHAN_MUX_CHMASK_EN
    .ch_en (ch_en_v),
`endif
    .i     (i),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .s     (s),
    .mode  (mode),
    .o     (o),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_ch  (o_ch)
  );

  chan_mux_seq #(.N_CH(6), .W(8)) dut6 (
    .clk   (clk),
    .rst   (rst),
`ifdef CHAN_MUX_CHMASK_EN
    .ch_en (ch_en6),
`endif
    .i     (i6),
    .i_vld (i_vld6),
    .i_rdy (i_rdy6),
    .s     (s6),
    .mode  (mode6),
    .o     (o6),
    .o_vld (o_vld6),
    .o_rdy (o_rdy6),
    .o_ch  (o_ch6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pack_data();
    for (int k = 0; k < 8; k++) i[k*8 +: 8] = dat[k];
  endtask

  function automatic vec_t mk(input logic md, input logic [2:0] sel, input logic [7:0] vld,
                              input logic rdy, input logic [7:0] e_rdy, input logic e_vld,
                              input logic [2:0] e_ch, input logic [7:0] e_o);
    vec_t v;
    v.md = md; v.sel = sel; v.vld = vld; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ch = e_ch; v.e_o = e_o;
    return v;
  endfunction

  // One clock: inputs already applied just after a falling edge.
  task automatic cycle(input string tag, output logic [7:0] rdy_seen);
    int         win;
    logic [7:0] eff;
    logic [7:0] exp_rdy;
    #1;
    eff = i_vld & ch_en_v;
    win = -1;
    if (!m_vld || o_rdy) begin
      if (mode == 1'b0) begin
        if (eff[s]) win = int'(s);
      end else begin
        for (int j = 0; j < 8; j++) begin
          int c;
          c = (m_ptr + j) % 8;
          if (win < 0 && eff[c]) win = c;
        end
      end
    end
    exp_rdy = (win >= 0) ? (8'h01 << win) : 8'h00;
    rdy_seen = i_rdy;
    chk({tag, "_i_rdy"}, i_rdy, exp_rdy);
    @(posedge clk);
    if (win >= 0) begin
      m_vld = 1'b1;
      m_o   = dat[win];
      m_ch  = win;
      if (mode == 1'b1) m_ptr = (win + 1) % 8;
    end else if (o_rdy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_o_vld"}, o_vld, m_vld);
    if (m_vld) begin
      chk({tag, "_o"}, o, m_o);
      chk({tag, "_o_ch"}, o_ch, m_ch);
    end
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_o   = 8'h00;
    m_ch  = 0;
    m_ptr = 0;
  endtask

  initial begin
    logic [7:0] rs;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ch_en_v = 8'hFF;
    ch_en6  = 6'h3F;
    i_vld = 8'hFF; mode = 1'b1; s = 3'd0; o_rdy = 1'b1;
    i6 = 48'h0; i_vld6 = 6'h00; s6 = 3'd0; mode6 = 1'b0; o_rdy6 = 1'b1;
    for (int k = 0; k < 8; k++) dat[k] = 8'hA0 + 8'(k);
    pack_data();
    model_reset();

    #2;
    chk("rst_o_vld", o_vld, 1'b0);
    chk("rst_o", o, 8'h00);
    chk("rst_o_ch", o_ch, 3'd0);
    chk("rst_i_rdy", i_rdy, 8'h00);

    @(negedge clk);
    rst = 1'b0;

    // directed vector table
    tbl.push_back(mk(1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01 << k, 1'b1, 3'(k), 8'hA0 + 8'(k)));
    tbl.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0));
    tbl.push_back(mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7));
    tbl.push_back(mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0));
    tbl.push_back(mk(1'b1, 3'd0, 8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd7, 8'hA7));
    tbl.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0));
    tbl.push_back(mk(1'b0, 3'd3, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00));
    tbl.push_back(mk(1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'hA3));
    tbl.push_back(mk(1'b0, 3'd2, 8'h04, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3));
    tbl.push_back(mk(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1));

    foreach (tbl[n]) begin
      mode = tbl[n].md; s = tbl[n].sel; i_vld = tbl[n].vld; o_rdy = tbl[n].rdy;
      cycle($sformatf("tbl%0d", n), rs);
      chk($sformatf("tbl%0d_vec_i_rdy", n), rs, tbl[n].e_rdy);
      chk($sformatf("tbl%0d_vec_o_vld", n), o_vld, tbl[n].e_vld);
      if (tbl[n].e_vld) begin
        chk($sformatf("tbl%0d_vec_o", n), o, tbl[n].e_o);
        chk($sformatf("tbl%0d_vec_o_ch", n), o_ch, tbl[n].e_ch);
      end
    end

    // reset pulse between edges while a word is held
    mode = 1'b1; i_vld = 8'hFF; o_rdy = 1'b0;
    cycle("hold", rs);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_o_vld", o_vld, 1'b0);
    chk("midrst_o", o, 8'h00);
    chk("midrst_o_ch", o_ch, 3'd0);
    chk("midrst_i_rdy", i_rdy, 8'h00);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    o_rdy = 1'b1;
    cycle("post_rst", rs);
    chk("post_rst_ch0", o_ch, 3'd0);

`ifdef CHAN_MUX_CHMASK_EN
    ch_en_v = 8'hFE; i_vld = 8'h01; mode = 1'b1; o_rdy = 1'b1;
    cycle("mask", rs);
    chk("mask_no_cap", o_vld, 1'b0);
    ch_en_v = 8'hFF;
`endif

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      mode  = 1'($urandom_range(0, 1));
      s     = 3'($urandom_range(0, 7));
      i_vld = 8'($urandom);
      o_rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) dat[k] = 8'($urandom);
      pack_data();
`ifdef CHAN_MUX_CHMASK_EN
      ch_en_v = 8'($urandom);
`endif
      cycle("rnd", rs);
    end
    i_vld = 8'h00;
    ch_en_v = 8'hFF;

    // six-channel instance: out-of-range fixed select never captures
    for (int k = 0; k < 6; k++) i6[k*8 +: 8] = 8'hB0 + 8'(k);
    mode6 = 1'b0; s6 = 3'd7; i_vld6 = 6'h3F; o_rdy6 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1 chk("n6_s7_i_rdy", i_rdy6, 6'h00);
      @(negedge clk);
      chk("n6_s7_o_vld", o_vld6, 1'b0);
    end
    s6 = 3'd5;
    #1 chk("n6_s5_i_rdy", i_rdy6, 6'h20);
    @(negedge clk);
    chk("n6_s5_o_vld", o_vld6, 1'b1);
    chk("n6_s5_o_ch", o_ch6, 3'd5);
    chk("n6_s5_o", o6, 8'hB5);
    s6 = 3'd6;
    #1 chk("n6_s6_i_rdy", i_rdy6, 6'h00);
    @(negedge clk);
    chk("n6_s6_o_vld", o_vld6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_mux_seq.md
CHAN_MUX_SEQ -- requirements
Module: chan_mux_seq

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, 2..64.
REQ-002 Parameter W, default 8: data width per channel, 1..64.
REQ-003 Derived constant SELW = max(1, clog2(N_CH)): select/channel-index width.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 i  in  N_CH*W  channel data; channel k occupies bits [k*W +: W].
REQ-008 i_vld  in  N_CH  per-channel data valid.
REQ-009 i_rdy  out  N_CH  per-channel accept strobe, combinational, at most one bit high.
REQ-010 s  in  SELW  channel select, fixed mode only.
REQ-011 mode  in  1  0 = fixed select, 1 = round-robin scan.
REQ-012 o  out  W  registered output data.
REQ-013 o_vld  out  1  output holds valid data.
REQ-014 o_rdy  in  1  downstream accepts o when o_vld & o_rdy.
REQ-015 o_ch  out  SELW  index of the channel that produced o.

Function
REQ-016 Output stage free: ~o_vld | o_rdy.
REQ-017 Fixed mode: capture when free, s < N_CH and i_vld[s]; load o with channel s and o_ch with s; i_rdy[s] = 1 for that cycle.
REQ-018 Fixed mode with s >= N_CH: no capture, all i_rdy = 0.
REQ-019 Scan mode: the winner is the first channel k with i_vld[k], searching from ptr upward and wrapping from N_CH-1 to 0; if free and a winner exists, capture it and assert i_rdy[k].
REQ-020 Scan mode: after each capture, ptr = winner+1, or 0 if winner = N_CH-1; otherwise ptr holds.
REQ-021 ptr is held, not cleared, in fixed mode and across mode changes; a mode change takes effect in the same cycle.
REQ-022 Latency: data captured at edge n appears on o with o_vld = 1 after edge n; full throughput is one transfer per cycle when o_rdy = 1.
REQ-023 On the same edge, a transfer out and a new capture give o_vld = 1 with the new data; a transfer out with no capture gives o_vld = 0.
REQ-024 While o_vld & ~o_rdy, o, o_ch and o_vld hold stable and all i_rdy = 0.

Reset
REQ-025 While rst is high: o = 0, o_vld = 0, o_ch = 0, ptr = 0, and i_rdy = 0 immediately.
REQ-026 Reset asserted mid-transfer discards the held word; no capture occurs on the first edge after release unless the conditions in REQ-017/REQ-019 are met.

Configuration
REQ-027 Macro CHAN_MUX_CHMASK_EN, when defined, adds input ch_en (width N_CH); a channel with ch_en[k] = 0 is treated as i_vld[k] = 0 in both modes, and fixed-mode selection of a disabled channel does not capture.
REQ-028 Without CHAN_MUX_CHMASK_EN, the ch_en port does not exist and all channels are enabled.

Structure
REQ-029 Package chan_mux_pkg holds the mode encoding constants (MODE_FIXED = 0, MODE_SCAN = 1), default N_CH and W, and the SELW helper function.
REQ-030 Sub-module rr_pick, parametrised by N_CH: inputs req[N_CH] and ptr[SELW]; outputs gnt (one-hot) and gnt_idx; purely combinational.

Verification
REQ-031 Fixed mode, s = 5, i_vld = 8'h20, ch5 data = 8'hA5, o_rdy = 1 -> one cycle later o = A5, o_ch = 5, o_vld = 1, and i_rdy = 8'h20 in the capture cycle.
REQ-032 Scan mode, i_vld = 8'hFF held, o_rdy = 1 -> o_ch sequence 0,1,...,7,0 on consecutive cycles, with no bubble.
REQ-033 Scan mode, i_vld = 8'h81, ptr = 1 -> ch7 is captured, then ch0 (wrap), then ch7.
REQ-034 Backpressure: o_rdy = 0 for 3 cycles with o_vld = 1 -> o and o_ch stable, i_rdy = 0; when o_rdy rises, the next word is loaded in that same cycle.
REQ-035 N_CH = 6, fixed mode, s = 7 -> o_vld stays 0 and i_rdy = 0.
REQ-036 rst pulsed between edges while o_vld = 1 -> o_vld = 0 and o = 0 immediately; after release, scan restarts from ch0; with CHAN_MUX_CHMASK_EN, ch_en = 8'hFE and i_vld = 8'h01 -> no capture.
